// File: rtl/snake_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl_if
//   Signal bundle between the snake game sequencer and its surroundings.
//   The board side (switches, buttons, sync, datapath status) is the master.
//   The sequencer is the slave.
//
//   Inputs to the sequencer:
//     SWPAUSE    pause switch level (asynchronous)
//     vert_sync  VGA vertical sync, active-low (asynchronous)
//     BTNU/L/R/D raw direction buttons, active-high (asynchronous)
//     apple_eat  head-on-apple level
//     collided   head hit border/body level
//
//   Outputs from the sequencer:
//     move_tick   one-cycle advance pulse
//     direction   committed direction (00 up, 01 left, 10 right, 11 down)
//     grow        lengthen flag, coincident with move_tick
//     game_state  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER
//     score       apples eaten, saturating at 255
//     speed_level current speed level
// ---------------------------------------------------------------------------
interface snake_game_ctrl_if;
    logic       SWPAUSE;
    logic       vert_sync;
    logic       BTNU;
    logic       BTNL;
    logic       BTNR;
    logic       BTND;
    logic       apple_eat;
    logic       collided;
    logic       move_tick;
    logic [1:0] direction;
    logic       grow;
    logic [1:0] game_state;
    logic [7:0] score;
    logic [2:0] speed_level;

    modport master (
        output SWPAUSE, vert_sync, BTNU, BTNL, BTNR, BTND, apple_eat, collided,
        input  move_tick, direction, grow, game_state, score, speed_level
    );

    modport slave (
        input  SWPAUSE, vert_sync, BTNU, BTNL, BTNR, BTND, apple_eat, collided,
        output move_tick, direction, grow, game_state, score, speed_level
    );
endinterface

// File: rtl/snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl
//   Central sequencer for the snake game, running on the 25 MHz pixel clock.
//   - Synchronises the pause switch, the vertical sync and the buttons.
//   - Debounces the buttons into one-cycle press events.
//   - Runs the IDLE/PLAY/PAUSE/OVER state machine.
//   - Derives the move tick from frame ticks.
//   - Commits direction changes, rejecting 180-degree reversals.
//   - Counts apples and raises the speed level.
//
//   Ports:
//     clock_25mhz  pixel clock, sole clock
//     SWRES        synchronous active-low reset
//     bus          snake_game_ctrl_if.slave (see interface header)
// ---------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int FRAMES_INIT      = 8,
    parameter int FRAMES_MIN       = 2,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int DEBOUNCE_CYCLES  = 250000
) (
    input  logic              clock_25mhz,
    input  logic              SWRES,
    snake_game_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_PLAY  = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_OVER  = 2'b11;

    localparam logic [1:0] DIR_RIGHT = 2'b10;

    localparam int SPEED_MAX = ((FRAMES_INIT - FRAMES_MIN) < 7) ? (FRAMES_INIT - FRAMES_MIN) : 7;
    localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]      EAT_LAST = 8'(APPLES_PER_LEVEL - 1);

    // Input conditioning registers
    logic [1:0]      pz_sync_q;
    logic [2:0]      vs_sync_q;      // [1:0] synchroniser, [2] previous sample
    logic [3:0]      btn_s1_q;       // bit index equals direction code: U,L,R,D
    logic [3:0]      btn_s2_q;
    logic [3:0]      db_lvl_q;
    logic [3:0]      db_prev_q;
    logic [DB_W-1:0] db_cnt_q [4];
    logic            eat_q;

    // Game state
    logic [1:0] state_q,     state_d;
    logic [1:0] dir_q,       dir_d;
    logic [1:0] pend_q,      pend_d;
    logic [7:0] score_q,     score_d;
    logic [2:0] speed_q,     speed_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [7:0] eat_cnt_q,   eat_cnt_d;
    logic       grow_pend_q, grow_pend_d;
    logic       move_tick_q, move_tick_d;
    logic       grow_q,      grow_d;

    logic       pause_s;
    logic       frame_tick;
    logic       eat_ev;
    logic [3:0] press_ev;
    logic       press_any;
    logic [1:0] press_dir;
    int         period_v;
    logic [7:0] period_m1;

    assign pause_s    = pz_sync_q[1];
    assign frame_tick = vs_sync_q[2] & ~vs_sync_q[1];
    assign eat_ev     = bus.apple_eat & ~eat_q;
    assign press_ev   = db_lvl_q & ~db_prev_q;
    assign press_any  = |press_ev;

    // Lowest index wins, giving U > L > R > D.
    always_comb begin
        press_dir = DIR_RIGHT;
        if (press_ev[3]) press_dir = 2'd3;
        if (press_ev[2]) press_dir = 2'd2;
        if (press_ev[1]) press_dir = 2'd1;
        if (press_ev[0]) press_dir = 2'd0;
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        score_d     = score_q;
        speed_d     = speed_q;
        frame_cnt_d = frame_cnt_q;
        eat_cnt_d   = eat_cnt_q;
        grow_pend_d = grow_pend_q;
        move_tick_d = 1'b0;
        grow_d      = 1'b0;

        period_v = FRAMES_INIT - int'(speed_q);
        if (period_v < FRAMES_MIN) period_v = FRAMES_MIN;
        period_m1 = 8'(period_v - 1);

        // The direction committed by a tick becomes visible one cycle later.
        if (move_tick_q) dir_d = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (press_any) begin
                    state_d = ST_PLAY;
                    if (press_dir != ~dir_q) pend_d = press_dir;
                end
            end
            ST_PLAY: begin
                if (bus.collided) begin
                    // Collision beats any tick, eat or press this cycle.
                    state_d = ST_OVER;
                end else if (pause_s) begin
                    state_d = ST_PAUSE;
                end else begin
                    // Reversal is judged against the committed direction.
                    if (press_any && (press_dir != ~dir_q)) pend_d = press_dir;

                    // ">=" also covers a counter left above a freshly shortened period.
                    if (frame_tick) begin
                        if (frame_cnt_q >= period_m1) begin
                            frame_cnt_d = 8'd0;
                            move_tick_d = 1'b1;
                            grow_d      = grow_pend_q;
                            grow_pend_d = 1'b0;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
                    end

                    // An eat on a tick-issuing cycle re-arms growth for the next tick.
                    if (eat_ev) begin
                        grow_pend_d = 1'b1;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        if (eat_cnt_q == EAT_LAST) begin
                            eat_cnt_d = 8'd0;
                            if (int'(speed_q) < SPEED_MAX) speed_d = speed_q + 3'd1;
                        end else begin
                            eat_cnt_d = eat_cnt_q + 8'd1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (!pause_s) state_d = ST_PLAY;
            end
            default: begin
                if (press_ev[0]) begin
                    state_d     = ST_IDLE;
                    dir_d       = DIR_RIGHT;
                    pend_d      = DIR_RIGHT;
                    score_d     = 8'd0;
                    speed_d     = 3'd0;
                    frame_cnt_d = 8'd0;
                    eat_cnt_d   = 8'd0;
                    grow_pend_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock_25mhz) begin
        if (!SWRES) begin
            pz_sync_q   <= 2'b00;
            vs_sync_q   <= 3'b111;   // idle-high sync, so no false frame tick
            btn_s1_q    <= 4'b0000;
            btn_s2_q    <= 4'b0000;
            db_lvl_q    <= 4'b0000;
            db_prev_q   <= 4'b0000;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            eat_q       <= 1'b0;
            state_q     <= ST_IDLE;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            score_q     <= 8'd0;
            speed_q     <= 3'd0;
            frame_cnt_q <= 8'd0;
            eat_cnt_q   <= 8'd0;
            grow_pend_q <= 1'b0;
            move_tick_q <= 1'b0;
            grow_q      <= 1'b0;
        end else begin
            pz_sync_q <= {pz_sync_q[0], bus.SWPAUSE};
            vs_sync_q <= {vs_sync_q[1:0], bus.vert_sync};
            btn_s1_q  <= {bus.BTND, bus.BTNR, bus.BTNL, bus.BTNU};
            btn_s2_q  <= btn_s1_q;
            db_prev_q <= db_lvl_q;
            // A level flips only after DEBOUNCE_CYCLES consecutive differing samples.
            for (int i = 0; i < 4; i++) begin
                if (btn_s2_q[i] != db_lvl_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_lvl_q[i] <= btn_s2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
            eat_q       <= bus.apple_eat;
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            score_q     <= score_d;
            speed_q     <= speed_d;
            frame_cnt_q <= frame_cnt_d;
            eat_cnt_q   <= eat_cnt_d;
            grow_pend_q <= grow_pend_d;
            move_tick_q <= move_tick_d;
            grow_q      <= grow_d;
        end
    end

    assign bus.move_tick   = move_tick_q;
    assign bus.direction   = dir_q;
    assign bus.grow        = grow_q;
    assign bus.game_state  = state_q;
    assign bus.score       = score_q;
    assign bus.speed_level = speed_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_game_ctrl
//   Bench for snake_game_ctrl with DEBOUNCE_CYCLES = 4.
//   A behavioural game model runs on every clock edge.
//   Each cycle, the DUT outputs are compared against the model.
//   Directed scenarios are followed by randomized play.
// ---------------------------------------------------------------------------
module tb_snake_game_ctrl;

    localparam int FI  = 8;
    localparam int FM  = 2;
    localparam int APL = 4;
    localparam int DB  = 4;

    logic clk;
    logic swres;
    int   n_chk;
    int   n_err;
    bit   mdl_on;
    bit   vs_fixed;

    snake_game_ctrl_if bus ();

    snake_game_ctrl #(
        .FRAMES_INIT      (FI),
        .FRAMES_MIN       (FM),
        .APPLES_PER_LEVEL (APL),
        .DEBOUNCE_CYCLES  (DB)
    ) dut (
        .clock_25mhz (clk),
        .SWRES       (swres),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_state;   // 0 idle, 1 play, 2 pause, 3 over
    int m_dir, m_pend, m_score, m_speed, m_fcnt, m_ecnt;
    bit m_gp, m_mt, m_gr;
    bit [1:0] pz_h;
    bit [2:0] vs_h;
    bit bh [4][2];
    int run_len [4];
    bit lvl [4];
    bit lvl_prev [4];
    bit apple_prev;

    function automatic int period_of(input int spd);
        int p;
        p = FI - spd;
        return (p < FM) ? FM : p;
    endfunction

    function automatic int speed_cap();
        return ((FI - FM) < 7) ? (FI - FM) : 7;
    endfunction

    always @(posedge clk) begin
        bit raw [4];
        bit press [4];
        bit pz, ft, eat;
        int pick, old_dir;
        bit new_mt, new_gr;
        raw[0] = bus.BTNU; raw[1] = bus.BTNL; raw[2] = bus.BTNR; raw[3] = bus.BTND;
        if (!swres) begin
            m_state = 0; m_dir = 2; m_pend = 2; m_score = 0; m_speed = 0;
            m_fcnt = 0; m_ecnt = 0; m_gp = 0; m_mt = 0; m_gr = 0;
            pz_h = 2'b00; vs_h = 3'b111; apple_prev = 0;
            for (int i = 0; i < 4; i++) begin
                bh[i][0] = 0; bh[i][1] = 0; run_len[i] = 0; lvl[i] = 0; lvl_prev[i] = 0;
            end
        end else begin
            // what the design sees during the cycle ending at this edge
            pz  = pz_h[1];
            ft  = vs_h[2] && !vs_h[1];
            eat = bus.apple_eat && !apple_prev;
            pick = -1;
            for (int i = 3; i >= 0; i--) begin
                press[i] = lvl[i] && !lvl_prev[i];
                if (press[i]) pick = i;
            end
            // advance the input conditioning
            pz_h = {pz_h[0], bus.SWPAUSE};
            vs_h = {vs_h[1:0], bus.vert_sync};
            for (int i = 0; i < 4; i++) begin
                lvl_prev[i] = lvl[i];
                if (bh[i][1] != lvl[i]) begin
                    run_len[i]++;
                    if (run_len[i] == DB) begin
                        lvl[i] = bh[i][1];
                        run_len[i] = 0;
                    end
                end else begin
                    run_len[i] = 0;
                end
                bh[i][1] = bh[i][0];
                bh[i][0] = raw[i];
            end
            apple_prev = bus.apple_eat;
            // game rules
            old_dir = m_dir;
            new_mt = 0; new_gr = 0;
            if (m_mt) m_dir = m_pend;
            case (m_state)
                0: if (pick >= 0) begin
                    m_state = 1;
                    if (pick != 3 - old_dir) m_pend = pick;
                end
                1: if (bus.collided) m_state = 3;
                   else if (pz) m_state = 2;
                   else begin
                       if (pick >= 0 && pick != 3 - old_dir) m_pend = pick;
                       if (ft) begin
                           if (m_fcnt >= period_of(m_speed) - 1) begin
                               m_fcnt = 0; new_mt = 1; new_gr = m_gp; m_gp = 0;
                           end else m_fcnt++;
                       end
                       if (eat) begin
                           m_gp = 1;
                           if (m_score < 255) m_score++;
                           m_ecnt++;
                           if (m_ecnt == APL) begin
                               m_ecnt = 0;
                               if (m_speed < speed_cap()) m_speed++;
                           end
                       end
                   end
                2: if (!pz) m_state = 1;
                default: if (press[0]) begin
                    m_state = 0; m_dir = 2; m_pend = 2; m_score = 0; m_speed = 0;
                    m_fcnt = 0; m_ecnt = 0; m_gp = 0;
                end
            endcase
            m_mt = new_mt;
            m_gr = new_gr;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (mdl_on) begin
            chk("move_tick",   32'(bus.move_tick),   32'(m_mt));
            chk("grow",        32'(bus.grow),        32'(m_gr));
            chk("direction",   32'(bus.direction),   32'(m_dir));
            chk("game_state",  32'(bus.game_state),  32'(m_state));
            chk("score",       32'(bus.score),       32'(m_score));
            chk("speed_level", 32'(bus.speed_level), 32'(m_speed));
        end
    end

    // vertical sync generator: low for two cycles per frame
    initial begin
        bus.vert_sync = 1'b1;
        forever begin
            int per;
            per = vs_fixed ? 12 : int'($urandom_range(6, 14));
            repeat (per - 2) @(negedge clk);
            bus.vert_sync = 1'b0;
            repeat (2) @(negedge clk);
            bus.vert_sync = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btns(input logic [3:0] m);
        bus.BTNU = m[0]; bus.BTNL = m[1]; bus.BTNR = m[2]; bus.BTND = m[3];
    endtask

    task automatic press_btn(input int idx);
        logic [3:0] m;
        m = '0;
        m[idx] = 1'b1;
        set_btns(m);
        cyc(10);
        set_btns(4'b0000);
        cyc(10);
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.move_tick && cycles < 3000);
        if (!bus.move_tick) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int c;
        n_chk = 0; n_err = 0; mdl_on = 0; vs_fixed = 1;
        swres = 1'b0;
        bus.SWPAUSE = 1'b0; bus.apple_eat = 1'b0; bus.collided = 1'b0;
        set_btns(4'b0000);
        cyc(3);
        mdl_on = 1;
        chk("rst_state", 32'(bus.game_state), 32'd0);
        chk("rst_dir",   32'(bus.direction),  32'd2);
        chk("rst_score", 32'(bus.score),      32'd0);
        swres = 1'b1;
        cyc(5);

        // bounce 1-0-1 never settles
        bus.BTNU = 1'b1; cyc(1); bus.BTNU = 1'b0; cyc(1); bus.BTNU = 1'b1; cyc(1); bus.BTNU = 1'b0;
        cyc(20);
        chk("bounce_idle", 32'(bus.game_state), 32'd0);

        press_btn(2);
        chk("start_play", 32'(bus.game_state), 32'd1);
        chk("start_dir",  32'(bus.direction),  32'd2);

        // speed 0: eight frames of twelve cycles per move
        wait_tick(c);
        wait_tick(c);
        chk("period8", 32'(c), 32'd96);
        cyc(1);
        chk("tick_width", 32'(bus.move_tick), 32'd0);

        // reversal ignored
        press_btn(1);
        wait_tick(c);
        cyc(2);
        chk("left_ignored", 32'(bus.direction), 32'd2);

        // up then down before a tick: down is not the reverse of right
        press_btn(0);
        press_btn(3);
        wait_tick(c);
        cyc(2);
        chk("down_final", 32'(bus.direction), 32'd3);

        // one long contact is one apple
        bus.apple_eat = 1'b1; cyc(1000); bus.apple_eat = 1'b0; cyc(2);
        chk("one_apple", 32'(bus.score), 32'd1);

        for (int i = 0; i < 35; i++) begin
            bus.apple_eat = 1'b1; cyc(3); bus.apple_eat = 1'b0; cyc(3);
        end
        chk("score36", 32'(bus.score),       32'd36);
        chk("speed6",  32'(bus.speed_level), 32'd6);
        wait_tick(c);
        wait_tick(c);
        chk("period2", 32'(c), 32'd24);

        // pause holds everything
        bus.SWPAUSE = 1'b1; cyc(10);
        chk("paused", 32'(bus.game_state), 32'd2);
        cyc(200);
        bus.SWPAUSE = 1'b0; cyc(5);
        chk("resumed", 32'(bus.game_state), 32'd1);

        // collision with a coincident apple
        bus.collided = 1'b1; bus.apple_eat = 1'b1; cyc(1);
        bus.collided = 1'b0; bus.apple_eat = 1'b0; cyc(3);
        chk("over",       32'(bus.game_state), 32'd3);
        chk("over_score", 32'(bus.score),      32'd36);
        press_btn(0);
        chk("back_idle",  32'(bus.game_state), 32'd0);
        chk("idle_score", 32'(bus.score),      32'd0);

        // randomized play
        vs_fixed = 0;
        for (int it = 0; it < 500; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 30) begin
                if ($urandom_range(0, 1) == 0) set_btns(4'($urandom_range(1, 15)));
                else begin
                    logic [3:0] m;
                    m = '0;
                    m[$urandom_range(0, 3)] = 1'b1;
                    set_btns(m);
                end
                cyc(int'($urandom_range(1, 10)));
                set_btns(4'b0000);
                cyc(int'($urandom_range(0, 6)));
            end else if (r < 62) begin
                bus.apple_eat = 1'b1; cyc(int'($urandom_range(1, 4)));
                bus.apple_eat = 1'b0; cyc(int'($urandom_range(1, 4)));
            end else if (r < 67) begin
                bus.SWPAUSE = ~bus.SWPAUSE;
                cyc(int'($urandom_range(1, 30)));
            end else if (r < 71) begin
                bus.collided = 1'b1; bus.apple_eat = ($urandom_range(0, 1) == 1);
                cyc(1);
                bus.collided = 1'b0; bus.apple_eat = 1'b0;
            end else if (r < 73) begin
                swres = 1'b0; cyc(int'($urandom_range(1, 2))); swres = 1'b1;
            end else begin
                cyc(int'($urandom_range(1, 60)));
            end
        end
        cyc(20);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
